// File: rtl/ppu_pkg.sv
// Shared PPU types and constants for the sprite evaluation slice.
// Build option SPRITE_OVF_BUG_EN is consumed by sprite_eval.
package ppu_pkg;

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    EVAL_Y,
    EVAL_COPY,
    EVAL_OVF,
    DONE
  } sprite_eval_state_t;

  localparam int         SEC_OAM_BYTES = 32;
  localparam logic [3:0] MAX_SPRITES   = 4'd8;

  localparam logic [8:0] CLEAR_START  = 9'd1;
  localparam logic [8:0] EVAL_START   = 9'd65;
  localparam logic [8:0] EVAL_END     = 9'd256;
  localparam logic [8:0] LAST_COL     = 9'd340;
  localparam logic [8:0] LAST_VIS_ROW = 9'd239;
  localparam logic [8:0] PRE_ROW      = 9'd261;

  // Wrapping 9-bit subtract: sprites above the line land far out of range.
  function automatic logic in_range(
    input logic [8:0] r,
    input logic [7:0] y,
    input logic       tall
  );
    logic [8:0] diff;
    diff = r - {1'b0, y};
    return diff < (tall ? 9'd16 : 9'd8);
  endfunction

endpackage

// File: rtl/sec_oam_ram.sv
// 32x8 secondary OAM: synchronous write, asynchronous read.
// Same-address read during a write returns the old byte.
module sec_oam_ram
  import ppu_pkg::*;
(
  input  logic       clk,
  input  logic       we_i,
  input  logic [4:0] waddr_i,
  input  logic [7:0] wdata_i,
  input  logic [4:0] raddr_i,
  output logic [7:0] rdata_o
);

  logic [7:0] mem [SEC_OAM_BYTES];

  always_ff @(posedge clk) begin
    if (we_i) mem[waddr_i] <= wdata_i;
  end

  assign rdata_o = mem[raddr_i];

endmodule

// File: rtl/sprite_eval.sv
// Per-scanline sprite evaluation into secondary OAM.
// SPRITE_OVF_BUG_EN: reproduce the diagonal overflow scan.
module sprite_eval
  import ppu_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ppu_clk_en,
  input  logic [8:0] row,
  input  logic [8:0] col,
  input  logic       sp_size,
  input  logic       render_en,
  output logic [7:0] eval_oam_addr,
  input  logic [7:0] eval_oam_data,
  input  logic [4:0] sec_oam_addr,
  output logic [7:0] sec_oam_data,
  output logic [3:0] sp_count,
  output logic       sp0_present,
  output logic       sp_over_set,
  output logic       sp_over_clr
);

  sprite_eval_state_t state_q, state_d;

  logic [5:0] n_q, n_d;
  logic [1:0] m_q, m_d;
  logic [3:0] cnt_q, cnt_d;
  logic       sp0_next_q, sp0_next_d;
  logic [3:0] sp_count_q, sp_count_d;
  logic       sp0_q, sp0_d;
  logic       ovf_set_q, ovf_set_d;
  logic       ovf_clr_q, ovf_clr_d;

  logic       active;
  logic       hit;
  logic       last_n;
  logic       we;
  logic [4:0] waddr;
  logic [7:0] wdata;

  always_comb begin
    active      = render_en && (row <= LAST_VIS_ROW);
    hit         = in_range(row, eval_oam_data, sp_size);
    last_n      = (n_q == 6'd63);
    state_d     = state_q;
    n_d         = n_q;
    m_d         = m_q;
    cnt_d       = cnt_q;
    sp0_next_d  = sp0_next_q;
    sp_count_d  = sp_count_q;
    sp0_d       = sp0_q;
    ovf_set_d   = 1'b0;
    ovf_clr_d   = (row == PRE_ROW) && (col == CLEAR_START);
    we          = 1'b0;
    waddr       = col[5:1];
    wdata       = 8'hFF;

    if (!active) begin
      state_d = IDLE;
    end else if (col == LAST_COL) begin
      state_d = IDLE;
    end else if (col == 9'd0) begin
      state_d    = CLEAR;
      n_d        = '0;
      m_d        = '0;
      cnt_d      = '0;
      sp0_next_d = 1'b0;
    end else if (col == EVAL_END) begin
      state_d = DONE;
    end else begin
      unique case (state_q)
        CLEAR: begin
          we = col[0] && (col < EVAL_START);
          if (col == EVAL_START - 9'd1) state_d = EVAL_Y;
        end
        EVAL_Y: begin
          if (!col[0]) begin
            if (hit) begin
              we      = 1'b1;
              waddr   = {cnt_q[2:0], 2'b00};
              wdata   = eval_oam_data;
              m_d     = 2'd1;
              state_d = EVAL_COPY;
              if (n_q == 6'd0) sp0_next_d = 1'b1;
            end else begin
              n_d = n_q + 6'd1;
              if (last_n) state_d = DONE;
            end
          end
        end
        EVAL_COPY: begin
          if (!col[0]) begin
            we    = 1'b1;
            waddr = {cnt_q[2:0], m_q};
            wdata = eval_oam_data;
            if (m_q == 2'd3) begin
              m_d   = 2'd0;
              cnt_d = cnt_q + 4'd1;
              n_d   = n_q + 6'd1;
              if (last_n) state_d = DONE;
              else if (cnt_q == MAX_SPRITES - 4'd1) state_d = EVAL_OVF;
              else state_d = EVAL_Y;
            end else begin
              m_d = m_q + 2'd1;
            end
          end
        end
        EVAL_OVF: begin
          if (!col[0]) begin
            if (hit) begin
              ovf_set_d = 1'b1;
              state_d   = DONE;
            end else begin
              n_d = n_q + 6'd1;
`ifdef SPRITE_OVF_BUG_EN
              m_d = m_q + 2'd1;
`else
              m_d = 2'd0;
`endif
              if (last_n) state_d = DONE;
            end
          end
        end
        default: ;
      endcase
    end

    // Render off holds the last list; a non-evaluated line reports none.
    if (col == EVAL_END && render_en) begin
      sp_count_d = (active && state_q != IDLE) ? cnt_q : 4'd0;
      sp0_d      = active && state_q != IDLE && sp0_next_q;
    end

    we = we && ppu_clk_en;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      n_q        <= '0;
      m_q        <= '0;
      cnt_q      <= '0;
      sp0_next_q <= 1'b0;
      sp_count_q <= '0;
      sp0_q      <= 1'b0;
      ovf_set_q  <= 1'b0;
      ovf_clr_q  <= 1'b0;
    end else if (ppu_clk_en) begin
      state_q    <= state_d;
      n_q        <= n_d;
      m_q        <= m_d;
      cnt_q      <= cnt_d;
      sp0_next_q <= sp0_next_d;
      sp_count_q <= sp_count_d;
      sp0_q      <= sp0_d;
      ovf_set_q  <= ovf_set_d;
      ovf_clr_q  <= ovf_clr_d;
    end
  end

  sec_oam_ram u_sec_oam (
    .clk     (clk),
    .we_i    (we),
    .waddr_i (waddr),
    .wdata_i (wdata),
    .raddr_i (sec_oam_addr),
    .rdata_o (sec_oam_data)
  );

  assign eval_oam_addr = {n_q, m_q};
  assign sp_count      = sp_count_q;
  assign sp0_present   = sp0_q;
  assign sp_over_set   = ovf_set_q;
  assign sp_over_clr   = ovf_clr_q;

endmodule

// File: doc/sprite_eval.md
# sprite_eval

Per-scanline sprite evaluation stage of the PPU, downstream of the CPU register interface and the OAM it fills. It reads primary OAM through a dedicated read port and finds up to 8 sprites that intersect the next scanline. It copies them into an internal 32-byte secondary OAM for the sprite fetch stage. It also drives the sprite-overflow set/clear strobes back into the PPUSTATUS logic.

## Interface
- No parameters; all sizes are fixed constants in the shared package.
- clk  in  1  system clock
- rst_n  in  1  asynchronous reset, active low
- ppu_clk_en  in  1  PPU dot enable; all state advances only when high
- row  in  9  current scanline: 0-239 visible, 240-260 post-render/vblank, 261 pre-render
- col  in  9  current dot, 0-340
- sp_size  in  1  PPUCTRL[5]; 0 = 8-pixel-tall sprites, 1 = 16-pixel-tall sprites
- render_en  in  1  PPUMASK[3] | PPUMASK[4]
- eval_oam_addr  out  8  primary OAM read address (OAM answers asynchronously)
- eval_oam_data  in  8  primary OAM read data
- sec_oam_addr  in  5  secondary OAM read address from the fetch stage
- sec_oam_data  out  8  secondary OAM read data (asynchronous)
- sp_count  out  4  sprites found on the last completed evaluation, 0-8
- sp0_present  out  1  sprite 0 is in the last completed list
- sp_over_set  out  1  one-dot pulse: sprite overflow detected
- sp_over_clr  out  1  one-dot pulse at row 261, col 1

## Operation
- States: IDLE, CLEAR, EVAL_Y, EVAL_COPY, EVAL_OVF, DONE. Counters: n (6b, sprite index), m (2b, byte index), cnt (4b, found count).
- Evaluation runs only when row ≤ 239 and render_en = 1. Otherwise the block stays in IDLE and performs no secondary-OAM writes.
- col 0 → IDLE. On col 1 enter CLEAR.
- CLEAR, cols 1-64: on each odd col, write 8'hFF to secondary address (col-1)>>1. This covers all 32 bytes.
- At col 65 enter EVAL_Y with n=0, m=0, cnt=0. Each byte step takes 2 dots:
  - odd dot: present eval_oam_addr = {n, m};
  - even dot: act on the data.
- In-range test: diff = row − {1'b0, y}, computed as 9-bit unsigned. The sprite is in range iff diff < (sp_size ? 16 : 8).
- EVAL_Y, cnt < 8:
  - In range: write y to secondary address {cnt[2:0], 2'b00}, set m=1 and go to EVAL_COPY. If n = 0, set sp0_next.
  - Not in range: n++.
- EVAL_COPY: copy bytes m=1..3 to {cnt[2:0], m}. After m=3: cnt++, m=0, n++, return to EVAL_Y.
- n wrapping past 63 → DONE. If cnt reaches 8 with n not wrapped → EVAL_OVF.
- EVAL_OVF: read {n, m}.
  - In range → pulse sp_over_set and go to DONE.
  - Not in range → n++ and go to DONE when n wraps. m is handled per Configuration.
- col 256 (any eval state): force DONE and latch sp_count ← cnt and sp0_present ← sp0_next. The worst case (8 copies plus 64 Y checks = 176 dots) completes before col 256.
- sp_count and sp0_present hold from the col-256 latch until the next col-256 latch. On lines with no evaluation they latch 0.
- render_en falling mid-line → IDLE immediately. Secondary OAM keeps partial contents. Latched outputs hold.

## Timing
- Reset values: eval_oam_addr=0, sp_count=0, sp0_present=0, sp_over_set=0, sp_over_clr=0, state IDLE, n=m=cnt=0.
- Secondary OAM contents are undefined after reset.
- Secondary OAM write is synchronous on the enabled dot. sec_oam_data is combinational from sec_oam_addr (0-cycle latency).
- sp_over_set and sp_over_clr are high for exactly one ppu_clk_en dot.
- A secondary-OAM write and a fetch-stage read of the same address on the same dot return the old data.

## Configuration
- SPRITE_OVF_BUG_EN defined: in EVAL_OVF, a not-in-range sprite increments both n and m (m wraps 3→0). This reproduces the hardware diagonal-scan bug, so false and missed overflows occur.
- SPRITE_OVF_BUG_EN undefined: m stays 0 in EVAL_OVF, giving exact overflow detection.

## Structure
- ppu_pkg holds:
  - the sprite_eval_state_t enum;
  - SEC_OAM_BYTES=32, MAX_SPRITES=8;
  - the column constants CLEAR_START=1, EVAL_START=65, EVAL_END=256.
- Sub-module sec_oam_ram: 32x8 with synchronous write and asynchronous read.

## Test plan
- All 64 sprites with y=8'hF0, row 10 → secondary OAM all 8'hFF, sp_count=0, no sp_over_set.
- Sprites 0 and 5 at y=20, sp_size=0, row 25 → sp_count=2, sp0_present=1, secondary bytes 0-7 equal OAM bytes 0-3 and 20-23.
- Same sprites, row 28 with sp_size=0 (diff=8) → sp_count=0. With sp_size=1 → sp_count=2.
- Nine sprites with y=50 (indices 0-8), row 52, macro undefined → sp_count=8, one sp_over_set pulse before col 256.
- Sprite y=8'hFF, row 0 → diff wraps to 9'h101, not in range, sp_count=0.
- Reset asserted at col 120 mid-copy → all outputs 0. After release the next line evaluates normally. sp_over_clr pulses at row 261, col 1.
